// File: rtl/register_writeback.sv
// register_writeback: final stage of the 20-bit pipeline processor.
// Retires instructions from execute and drives the register-file write port.
// A load parks the stage in WAIT_MEM until mem_ready arrives or the wait
// times out. The stage also publishes a pending-destination mask for decode
// hazard checks and keeps a wrapping count of retired instructions.
// Optional feature: define WB_R0_HARDWIRED_EN to make register 0 read-only.
// Every write whose destination is R0 is then dropped, but the instruction
// still retires.
module register_writeback #(
    parameter int         DATA_W      = 16,
    parameter logic [3:0] OP_LOAD     = 4'b1011,
    parameter logic [3:0] OP_STORE    = 4'b1100,
    parameter logic [3:0] OP_NOP      = 4'b0000,
    parameter int         MEM_TIMEOUT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [19:0]       instruction,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ready_out,
    output logic              rf_write_en,
    output logic [3:0]        rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [15:0]       pending_mask,
    output logic [15:0]       retired_count,
    output logic              mem_timeout_err
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

`ifdef WB_R0_HARDWIRED_EN
    localparam bit R0_HARDWIRED = 1'b1;
`else
    localparam bit R0_HARDWIRED = 1'b0;
`endif

    // The wait counter only has to reach MEM_TIMEOUT-2, where the next
    // cycle without data aborts the load.
    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 2);

    state_t      state;
    logic [TW-1:0] wait_cnt;
    logic [3:0]  load_dest;

    logic [3:0]  opcode;
    logic [3:0]  dest;
    logic        accept;
    logic        dest_writable;
    logic        load_writable;
    logic        unused_bits;

    assign opcode    = instruction[19:16];
    assign dest      = instruction[15:12];
    assign ready_out = (state == IDLE);
    assign accept    = valid_in && ready_out;

    // A hardwired R0 can never be written, so a write to it is never issued
    // and is never tracked as pending.
    assign dest_writable = !(R0_HARDWIRED && (dest == 4'd0));
    assign load_writable = !(R0_HARDWIRED && (load_dest == 4'd0));

    // The low instruction bits hold source fields and immediates. Those
    // belong to the earlier stages, so this stage does not look at them.
    assign unused_bits = ^instruction[11:0];

    // Stage FSM: retire instructions, sequence loads, and register all outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            load_dest       <= '0;
            rf_write_en     <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            pending_mask    <= '0;
            retired_count   <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every read in this
            // block sees the pre-edge value, so the statement order does not
            // change the hardware. The strobe defaults low here and is
            // raised again only in the cycle that produces a write.
            rf_write_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (opcode == OP_LOAD) begin
                            state     <= WAIT_MEM;
                            load_dest <= dest;
                            wait_cnt  <= '0;
                            if (dest_writable) begin
                                pending_mask <= 16'd1 << dest;
                            end
                        end else if ((opcode == OP_NOP) || (opcode == OP_STORE)) begin
                            retired_count <= retired_count + 16'd1;
                        end else begin
                            // ALU ops commit in the very next cycle. No load
                            // can be in flight while the stage is in IDLE, so
                            // pending_mask does not need to track them.
                            retired_count <= retired_count + 16'd1;
                            if (dest_writable) begin
                                rf_write_en   <= 1'b1;
                                rf_write_addr <= dest;
                                rf_write_data <= alu_result;
                            end
                        end
                    end
                end

                WAIT_MEM: begin
                    if (mem_ready) begin
                        // Arriving data beats a timeout that falls in the same cycle.
                        state         <= IDLE;
                        pending_mask  <= '0;
                        retired_count <= retired_count + 16'd1;
                        if (load_writable) begin
                            rf_write_en   <= 1'b1;
                            rf_write_addr <= load_dest;
                            rf_write_data <= mem_data;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state           <= IDLE;
                        wait_cnt        <= wait_cnt + 1'b1;
                        pending_mask    <= '0;
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Self-checking bench for register_writeback.
// Every register-file write the bench expects is pushed to a scoreboard queue
// when its stimulus is driven. A monitor pops and compares one entry for
// every write strobe that the DUT raises.
module tb_register_writeback;

    localparam int DATA_W = 16;

    logic              clock;
    logic              reset;
    logic              valid_in;
    logic [19:0]       instruction;
    logic [DATA_W-1:0] alu_result;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;
    logic              ready_out;
    logic              rf_write_en;
    logic [3:0]        rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [15:0]       pending_mask;
    logic [15:0]       retired_count;
    logic              mem_timeout_err;

    typedef struct packed {
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    register_writeback dut (
        .clock          (clock),
        .reset          (reset),
        .valid_in       (valid_in),
        .instruction    (instruction),
        .alu_result     (alu_result),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .ready_out      (ready_out),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .pending_mask   (pending_mask),
        .retired_count  (retired_count),
        .mem_timeout_err(mem_timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: every write strobe must match the oldest expected write
    always @(negedge clock) begin : monitor
        wr_t e;
        if (rf_write_en !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got en=%b addr=%0d data=%h, expected no write",
                         rf_write_en, rf_write_addr, rf_write_data);
            end else begin
                e = exp_q.pop_front();
                if (rf_write_en !== 1'b1 || rf_write_addr !== e.addr || rf_write_data !== e.data) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             rf_write_addr, rf_write_data, e.addr, e.data);
                end
            end
        end
    end

    // Watchdog: the bench must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        valid_in    = 1'b0;
        instruction = '0;
        alu_result  = '0;
        mem_ready   = 1'b0;
        mem_data    = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [19:0] instr, input logic [DATA_W-1:0] res);
        valid_in    = 1'b1;
        instruction = instr;
        alu_result  = res;
        step();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        check_val("reset_ready", ready_out, 1);
        check_val("reset_en", rf_write_en, 0);
        check_val("reset_pending", pending_mask, 0);
        check_val("reset_count", retired_count, 0);
        check_val("reset_err", mem_timeout_err, 0);
        // Reset while a load is waiting: the load is abandoned and nothing is written
        issue({4'hB, 4'h9, 12'h000}, '0);
        step(); step(); step();
        check_val("midload_pending", pending_mask, 16'h0200);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("midload_ready", ready_out, 1);
        check_val("midload_pending_clr", pending_mask, 0);
        check_val("midload_addr", rf_write_addr, 0);
        check_val("midload_data", rf_write_data, 0);
        mem_ready = 1'b1;
        mem_data  = 16'hDEAD;
        step();
        mem_ready = 1'b0;
        check_val("midload_no_write", rf_write_en, 0);
        check_val("midload_count", retired_count, 0);
    endtask

    task automatic test_alu();
        do_reset();
        exp_q.push_back('{addr: 4'd5, data: 16'h1234});
        issue(20'h25034, 16'h1234);
        check_val("alu_en", rf_write_en, 1);
        check_val("alu_addr", rf_write_addr, 5);
        check_val("alu_data", rf_write_data, 16'h1234);
        check_val("alu_count", retired_count, 1);
        step();
        check_val("alu_en_drop", rf_write_en, 0);
    endtask

    task automatic test_store_nop();
        do_reset();
        issue(20'hC1200, 16'hAAAA);
        check_val("store_no_write", rf_write_en, 0);
        issue(20'h00000, 16'h5555);
        check_val("nop_no_write", rf_write_en, 0);
        check_val("store_nop_count", retired_count, 2);
        // mem_ready while idle must be ignored
        mem_ready = 1'b1;
        mem_data  = 16'h7777;
        step();
        mem_ready = 1'b0;
        check_val("idle_mem_ready", rf_write_en, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [3:0]  d;
            logic [15:0] v;
            d = 4'(i + 1);
            v = 16'(16'h1000 + i * 16'h0111);
            exp_q.push_back('{addr: d, data: v});
            valid_in    = 1'b1;
            instruction = {4'h3, d, 12'h000};
            alu_result  = v;
            step();
            check_val("b2b_en", rf_write_en, 1);
            check_val("b2b_addr", rf_write_addr, d);
        end
        valid_in = 1'b0;
        check_val("b2b_count", retired_count, 3);
        step();
        check_val("b2b_en_drop", rf_write_en, 0);
    endtask

    task automatic test_load();
        do_reset();
        issue({4'hB, 4'h7, 12'h000}, '0);
        for (int i = 0; i < 2; i++) begin
            check_val("load_wait_ready", ready_out, 0);
            check_val("load_wait_pending", pending_mask, 16'h0080);
            step();
        end
        check_val("load_wait_pending2", pending_mask, 16'h0080);
        mem_ready = 1'b1;
        mem_data  = 16'hBEEF;
        exp_q.push_back('{addr: 4'd7, data: 16'hBEEF});
        step();
        mem_ready = 1'b0;
        check_val("load_en", rf_write_en, 1);
        check_val("load_addr", rf_write_addr, 7);
        check_val("load_data", rf_write_data, 16'hBEEF);
        check_val("load_pending_clr", pending_mask, 0);
        check_val("load_ready", ready_out, 1);
        check_val("load_count", retired_count, 1);
    endtask

    task automatic test_timeout();
        do_reset();
        issue({4'hB, 4'h3, 12'h000}, '0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check_val("to_err_early", mem_timeout_err, 0);
            check_val("to_ready_early", ready_out, 0);
        end
        step();
        check_val("to_err", mem_timeout_err, 1);
        check_val("to_no_write", rf_write_en, 0);
        check_val("to_pending", pending_mask, 0);
        check_val("to_count", retired_count, 0);
        check_val("to_ready", ready_out, 1);
        // The error flag stays set across later traffic
        exp_q.push_back('{addr: 4'd4, data: 16'h0042});
        issue(20'h14000, 16'h0042);
        check_val("to_err_sticky", mem_timeout_err, 1);
        // mem_ready arriving on the final waiting cycle commits with no error
        do_reset();
        issue({4'hB, 4'h3, 12'h000}, '0);
        for (int i = 1; i <= 6; i++) step();
        mem_ready = 1'b1;
        mem_data  = 16'h5A5A;
        exp_q.push_back('{addr: 4'd3, data: 16'h5A5A});
        step();
        mem_ready = 1'b0;
        check_val("to_last_en", rf_write_en, 1);
        check_val("to_last_err", mem_timeout_err, 0);
        check_val("to_last_count", retired_count, 1);
    endtask

    task automatic test_r0();
        logic r0_hw;
`ifdef WB_R0_HARDWIRED_EN
        r0_hw = 1'b1;
`else
        r0_hw = 1'b0;
`endif
        do_reset();
        if (!r0_hw) exp_q.push_back('{addr: 4'd0, data: 16'h00FF});
        issue(20'h20000, 16'h00FF);
        check_val("r0_alu_en", rf_write_en, !r0_hw);
        check_val("r0_alu_count", retired_count, 1);
        issue({4'hB, 4'h0, 12'h000}, '0);
        check_val("r0_load_pending", pending_mask, r0_hw ? 16'h0000 : 16'h0001);
        check_val("r0_load_wait", ready_out, 0);
        mem_ready = 1'b1;
        mem_data  = 16'hCAFE;
        if (!r0_hw) exp_q.push_back('{addr: 4'd0, data: 16'hCAFE});
        step();
        mem_ready = 1'b0;
        check_val("r0_load_en", rf_write_en, !r0_hw);
        check_val("r0_load_count", retired_count, 2);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_nop();
        test_back_to_back();
        test_load();
        test_timeout();
        test_r0();
        step();
        check_val("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
